clock_enable_gen: RTL and testbench

Derives slow, synchronous timing from the single system clock `Clk` without creating new clock domains. It emits a one-cycle `Tick` enable every `Div+1` clock cycles and a `Phase` square wave that toggles on each tick. Downstream sequential blocks (multicycle datapath, display/IO refresh, testbench pacing) use these instead of gated or divided clocks. Run/pause control and divisor reload are synchronous to `Clk`.

---
 rtl/clock_enable_gen_pkg.sv | 13 +
 rtl/clock_enable_gen_tick_counter.sv | 21 ++
 rtl/clock_enable_gen.sv | 82 ++++++++
 tb/tb_clock_enable_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_enable_gen_pkg.sv
// Shared definitions for clock_enable_gen: FSM state encoding and default widths.
package clock_enable_gen_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/clock_enable_gen_tick_counter.sv
// Free-running wrap-around event counter: increments on each cycle with en=1.
module tick_counter
    import clock_enable_gen_defs::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// Clock-enable generator: one-cycle Tick every Div+1 cycles plus a Phase square wave.
// Define TICK_COUNTER_EN to add the TickCount output and its counter.
module clock_enable_gen
    import clock_enable_gen_defs::*;
#(
    parameter int DIV_W = DEF_DIV_W
`ifdef TICK_COUNTER_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Run,
    input  logic             Load,
    input  logic [DIV_W-1:0] Div,
    output logic             Tick,
    output logic             Phase,
    output logic             Running,
    output state_t           dbg_state
`ifdef TICK_COUNTER_EN
    , output logic [CNT_W-1:0] TickCount
`endif
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    state_t           state;

    assign dbg_state = state;

    // Load outranks Run; a paused count resumes from where it stopped.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_q   <= '0;
            cnt     <= '0;
            Tick    <= 1'b0;
            Phase   <= 1'b0;
            Running <= 1'b0;
            state   <= IDLE;
        end else if (Load) begin
            div_q   <= Div;
            cnt     <= '0;
            Tick    <= 1'b0;
            Running <= 1'b0;
            state   <= IDLE;
        end else if (Run) begin
            state   <= RUN;
            Running <= 1'b1;
            if (cnt == div_q) begin
                cnt   <= '0;
                Tick  <= 1'b1;
                Phase <= ~Phase;
            end else begin
                cnt  <= DIV_W'(cnt + 1'b1);
                Tick <= 1'b0;
            end
        end else begin
            Tick    <= 1'b0;
            Running <= 1'b0;
            if (state == RUN) begin
                state <= PAUSE;
            end
        end
    end

`ifdef TICK_COUNTER_EN
    logic tick_fire;

    // Same condition that sets Tick, so the count lands together with the pulse.
    assign tick_fire = !Load && Run && (cnt == div_q);

    tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_counter (
        .clk   (Clk),
        .rst   (Rst),
        .en    (tick_fire),
        .count (TickCount)
    );
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen (covers TickCount when TICK_COUNTER_EN is defined).
module tb_clock_enable_gen;
    import clock_enable_gen_defs::*;

    localparam int DIV_W = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             load;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             phase;
    logic             running;
    state_t           dbg_state;
`ifdef TICK_COUNTER_EN
    logic [CNT_W-1:0] tick_count;
    logic [CNT_W-1:0] m_tc;
`endif

    int checks   = 0;
    int failures = 0;

    // {tick, phase, running, state} expected after each edge
    logic [4:0] exp_q[$];
    logic [4:0] exp;

    logic [DIV_W-1:0] m_div;
    logic [DIV_W-1:0] m_cnt;
    logic             m_tick;
    logic             m_phase;
    logic             m_running;
    state_t           m_state;

    always #5 clk = ~clk;

    clock_enable_gen #(
        .DIV_W(DIV_W)
`ifdef TICK_COUNTER_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Run       (run),
        .Load      (load),
        .Div       (div),
        .Tick      (tick),
        .Phase     (phase),
        .Running   (running),
        .dbg_state (dbg_state)
`ifdef TICK_COUNTER_EN
        , .TickCount (tick_count)
`endif
    );

    // Drive one cycle of inputs, predict the post-edge outputs, sample #1 after the edge.
    task automatic drive_cycle(input logic r, input logic l, input logic rn,
                               input logic [DIV_W-1:0] d);
        @(negedge clk);
        rst  = r;
        load = l;
        run  = rn;
        div  = d;
        if (r) begin
            m_div = '0; m_cnt = '0; m_tick = 1'b0; m_phase = 1'b0;
            m_running = 1'b0; m_state = IDLE;
`ifdef TICK_COUNTER_EN
            m_tc = '0;
`endif
        end else if (l) begin
            m_div = d; m_cnt = '0; m_tick = 1'b0; m_running = 1'b0; m_state = IDLE;
        end else if (rn) begin
            m_state   = RUN;
            m_running = 1'b1;
            m_tick    = (m_cnt == m_div);
            if (m_tick) begin
                m_cnt   = '0;
                m_phase = ~m_phase;
`ifdef TICK_COUNTER_EN
                m_tc = m_tc + 1'b1;
`endif
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end else begin
            m_tick    = 1'b0;
            m_running = 1'b0;
            if (m_state == RUN) m_state = PAUSE;
        end
        exp_q.push_back({m_tick, m_phase, m_running, m_state});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp) begin
                failures++;
                $display("FAIL reset_sb cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
        end
        checks++;
        if ({tick, phase, running} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000", {tick, phase, running});
        end
`ifdef TICK_COUNTER_EN
        checks++;
        if (tick_count !== '0) begin
            failures++;
            $display("FAIL reset_tickcount got=%0d exp=0", tick_count);
        end
`endif
    endtask

    task automatic test_div3();
        int pos[$];
        logic ph[$];
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd3);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp) begin
                failures++;
                $display("FAIL div3_sb cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
            if (tick === 1'b1) begin
                pos.push_back(i);
                ph.push_back(phase);
            end
        end
        checks++;
        if (pos.size() != 5) begin
            failures++;
            $display("FAIL div3_tick_count got=%0d exp=5", pos.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (pos[j] != 4 * (j + 1) || ph[j] !== ((j % 2) == 0)) begin
                    failures++;
                    $display("FAIL div3_tick%0d got=cyc%0d/ph%b exp=cyc%0d/ph%b",
                             j, pos[j], ph[j], 4 * (j + 1), (j % 2) == 0);
                end
            end
        end
`ifdef TICK_COUNTER_EN
        checks++;
        if (tick_count !== 32'd5) begin
            failures++;
            $display("FAIL div3_tickcount got=%0d exp=5", tick_count);
        end
`endif
    endtask

    task automatic test_div0();
        logic prev;
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd0);
        void'(exp_q.pop_front());
        prev = phase;
        for (int i = 1; i <= 5; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp || tick !== 1'b1 || phase === prev) begin
                failures++;
                $display("FAIL div0_cyc%0d got=%b exp=%b prev_phase=%b",
                         i, {tick, phase, running, dbg_state}, exp, prev);
            end
            prev = phase;
        end
    endtask

    task automatic test_pause();
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd4);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp || running !== 1'b1) begin
                failures++;
                $display("FAIL pause_run cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp || tick !== 1'b0 || running !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp || tick !== (i == 3) || running !== 1'b1) begin
                failures++;
                $display("FAIL pause_resume cyc=%0d got=%b exp=%b tick_exp=%b",
                         i, {tick, phase, running, dbg_state}, exp, i == 3);
            end
        end
    endtask

    task automatic test_load_mid();
        int first;
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd5);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            void'(exp_q.pop_front());
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 8'd7);
        exp = exp_q.pop_front();
        checks++;
        if ({tick, phase, running, dbg_state} !== exp || tick !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL load_mid_strobe got=%b exp=%b", {tick, phase, running, dbg_state}, exp);
        end
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp) begin
                failures++;
                $display("FAIL load_mid_sb cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
            if (tick === 1'b1 && first == 0) first = i;
        end
        checks++;
        if (first != 8) begin
            failures++;
            $display("FAIL load_mid_first_tick got=%0d exp=8", first);
        end
    endtask

    task automatic test_wrap();
        int pos[$];
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd255);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 512; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp) begin
                failures++;
                $display("FAIL wrap_sb cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
            if (tick === 1'b1) pos.push_back(i);
        end
        checks++;
        if (pos.size() != 2 || pos[0] != 256 || pos[1] != 512) begin
            failures++;
            $display("FAIL wrap_ticks got_n=%0d exp=ticks at 256,512", pos.size());
        end
    endtask

    task automatic test_rst_mid();
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd3);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            void'(exp_q.pop_front());
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'd0);
        exp = exp_q.pop_front();
        checks++;
        if ({tick, phase, running, dbg_state} !== exp || {tick, phase, running} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid got=%b exp=%b", {tick, phase, running, dbg_state}, exp);
        end
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd0);
            exp = exp_q.pop_front();
            checks++;
            if ({tick, phase, running, dbg_state} !== exp) begin
                failures++;
                $display("FAIL rst_mid_run cyc=%0d got=%b exp=%b", i, {tick, phase, running, dbg_state}, exp);
            end
        end
`ifdef TICK_COUNTER_EN
        checks++;
        if (tick_count !== 32'd3) begin
            failures++;
            $display("FAIL rst_mid_tickcount got=%0d exp=3", tick_count);
        end
`endif
    endtask

    initial begin
        rst  = 1'b1;
        run  = 1'b0;
        load = 1'b0;
        div  = '0;
        test_reset();
        test_div3();
        test_div0();
        test_pause();
        test_load_mid();
        test_wrap();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
